cpu_mem_responder: RTL
======================

Name: cpu_mem_responder

Overview:
- Memory-side responder for the custom CPU's instruction and data channels.
- Answers instruction fetches and loads/stores from one shared word-addressed RAM, with configurable request-accept and response latencies.
- Serves as the simulation and FPGA memory model behind the CPU, and as the latency-stress target for the CPU's handshake FSM.

Parameters:
ADDR_W, 12, word-address width; RAM holds 2^ADDR_W 32-bit words.
REQ_LAT, 1, cycles between first sampling a request Valid and asserting its Ready (0..15).
RESP_LAT, 2, cycles from request acceptance to the response Valid (0..15).
INIT_FILE, "", hex image loaded into the RAM at elaboration; empty means all zeros.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
PC  in  32  fetch byte address
Inst_Req_Valid  in  1  fetch request valid
Inst_Req_Ready  out  1  fetch request accepted
Instruction  out  32  fetched word
Inst_Valid  out  1  Instruction valid
Inst_Ready  in  1  CPU accepts Instruction
Address  in  32  data byte address (bits [1:0] ignored)
MemWrite  in  1  store request
Write_data  in  32  store data, lane-aligned
Write_strb  in  4  byte-lane write enables
MemRead  in  1  load request
Mem_Req_Ready  out  1  data request accepted
Read_data  out  32  loaded word
Read_data_Valid  out  1  Read_data valid
Read_data_Ready  in  1  CPU accepts Read_data
protocol_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (asynchronous, while rst=1): both FSMs go to IDLE; counters 0; all Ready/Valid outputs 0; Instruction=0; Read_data=0; protocol_err=0. RAM contents are not cleared.
- Word index = byte address[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Instruction FSM (states I_IDLE, I_REQ, I_LAT, I_RESP):
  - I_IDLE: when Inst_Req_Valid=1, go to I_REQ and load cnt=REQ_LAT.
  - I_REQ: Inst_Req_Ready=(cnt==0), decoded from registered state. While cnt>0, decrement cnt.
  - I_REQ fire (Valid&Ready at a clock edge): latch the PC word index; go to I_LAT with cnt=RESP_LAT, or straight to I_RESP if RESP_LAT=0.
  - I_REQ with Valid dropped before fire: return to I_IDLE and set protocol_err.
  - I_LAT: decrement cnt; when cnt==0, go to I_RESP.
  - Entering I_RESP: register Instruction=RAM[latched index] and set Inst_Valid=1.
  - I_RESP: hold Instruction and Inst_Valid until Inst_Ready=1; on that edge clear Inst_Valid and go to I_IDLE.
  - Minimum latency with REQ_LAT=0, RESP_LAT=0: Valid in cycle 0, Ready in cycle 1, Inst_Valid in cycle 2.
- Data FSM (states D_IDLE, D_REQ, D_LAT, D_RESP) uses the same timing rules. Request = MemRead|MemWrite; ready output is Mem_Req_Ready.
  - Store fire: write RAM byte lane i from Write_data[8i+7:8i] where Write_strb[i]=1; return to D_IDLE. No response is generated.
  - Write_strb=0000 on a store: handshake completes, RAM is unchanged.
  - Load fire: follows the instruction path, driving Read_data and Read_data_Valid, released by Read_data_Ready.
  - MemRead&MemWrite both high at fire: perform the write only, give no read response, set protocol_err.
- The two FSMs run independently and may be active in the same cycle. The RAM has one write port and two read ports.
- Read-during-write at the same edge to the same word: the response register captures the old data; the new data is visible from the next read.
- A Ready output never asserts before its request has been sampled in IDLE, so there is no same-cycle combinational Valid-to-Ready path.
- Reset asserted mid-transaction: pending stores are dropped unless the write edge already occurred; pending responses are discarded; both FSMs restart in IDLE.
- protocol_err clears only on rst.

Test Plan:
- Fetch timing: REQ_LAT=2, RESP_LAT=3, RAM[0x10]=0x3C01ABCD, PC=0x40 with Valid at cycle 0 -> Ready high only in cycle 3; Inst_Valid rises in cycle 7 with Instruction=0x3C01ABCD.
- Store/load: store Address=0x100, Write_data=0xDEADBEEF, strb=1111, then store Write_data=0x00AA0000, strb=0100 -> a load from 0x100 returns 0xDEAABEEF; strb=0000 leaves it unchanged.
- Backpressure: Inst_Ready held low 5 cycles after Inst_Valid -> Instruction and Inst_Valid stay stable; they clear one cycle after Inst_Ready=1.
- Concurrency and wrap: fetch and load issued the same cycle to words 0 and 2^ADDR_W -> both respond with RAM[0] independently.
- Violations: MemRead=MemWrite=1 -> write performed, no Read_data_Valid, protocol_err=1. Inst_Req_Valid dropped during I_REQ -> protocol_err=1, FSM back in I_IDLE.
- Reset mid-response: rst pulsed while Read_data_Valid=1 -> Valid drops asynchronously to 0; the next load after reset completes normally.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Memory-side model behind the CPU: one shared word-addressed RAM serving an
// instruction-fetch channel and a load/store channel, each through its own
// handshake FSM with programmable request-accept and response latencies.
module cpu_mem_responder #(
    parameter int    ADDR_W    = 12,
    parameter int    REQ_LAT   = 1,
    parameter int    RESP_LAT  = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready,
    output logic        protocol_err
);

    localparam int         DEPTH       = 1 << ADDR_W;
    localparam logic [3:0] REQ_CNT     = 4'(REQ_LAT);
    // The LAT state is left on the edge where the counter reads zero, so it
    // is loaded with one less than the response latency.
    localparam logic [3:0] LAT_CNT     = (RESP_LAT > 0) ? 4'(RESP_LAT - 1) : 4'd0;
    localparam bit         DIRECT_RESP = (RESP_LAT == 0);

    typedef enum logic [1:0] {I_IDLE, I_REQ, I_LAT, I_RESP} i_state_t;
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_LAT, D_RESP} d_state_t;

    // Shared storage: one write port (stores), two read ports (fetch, load).
    logic [31:0] mem [DEPTH];

    i_state_t          i_state_q;
    logic [3:0]        i_cnt_q;
    logic [ADDR_W-1:0] i_idx_q;
    logic [31:0]       instr_q;
    logic              inst_valid_q;

    d_state_t          d_state_q;
    logic [3:0]        d_cnt_q;
    logic [ADDR_W-1:0] d_idx_q;
    logic [31:0]       rdata_q;
    logic              rdata_valid_q;

    logic              err_q;

    logic [ADDR_W-1:0] pc_idx;
    logic [ADDR_W-1:0] addr_idx;
    logic              data_req;
    logic              inst_fire;
    logic              data_fire;
    logic              data_wr;
    logic              i_drop;
    logic              d_drop;
    logic              d_both;
    logic              unused_bits;

    // Word index: byte address bits above the lane, wrapped to the RAM size.
    assign pc_idx   = PC[ADDR_W+1:2];
    assign addr_idx = Address[ADDR_W+1:2];
    assign unused_bits = ^{PC[31:ADDR_W+2], PC[1:0], Address[31:ADDR_W+2], Address[1:0]};

    // Ready is decoded purely from registered state, so it can never follow
    // a Valid combinationally within the same cycle.
    assign Inst_Req_Ready = (i_state_q == I_REQ) && (i_cnt_q == 4'd0);
    assign Mem_Req_Ready  = (d_state_q == D_REQ) && (d_cnt_q == 4'd0);

    assign data_req  = MemRead | MemWrite;
    assign inst_fire = Inst_Req_Ready && Inst_Req_Valid;
    assign data_fire = Mem_Req_Ready && data_req;
    assign data_wr   = data_fire && MemWrite;
    assign i_drop    = (i_state_q == I_REQ) && !Inst_Req_Valid;
    assign d_drop    = (d_state_q == D_REQ) && !data_req;
    assign d_both    = data_fire && MemRead && MemWrite;

    assign Instruction     = instr_q;
    assign Inst_Valid      = inst_valid_q;
    assign Read_data       = rdata_q;
    assign Read_data_Valid = rdata_valid_q;
    assign protocol_err    = err_q;

    // Store port: byte-lane merge at the accept edge. Reads on the same edge
    // use non-blocking semantics and therefore return the old word.
    always_ff @(posedge clk) begin
        if (data_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (Write_strb[b]) begin
                    mem[addr_idx][8*b +: 8] <= Write_data[8*b +: 8];
                end
            end
        end
    end

    // Instruction channel FSM with registered Instruction / Inst_Valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_state_q    <= I_IDLE;
            i_cnt_q      <= 4'd0;
            i_idx_q      <= '0;
            instr_q      <= 32'd0;
            inst_valid_q <= 1'b0;
        end else begin
            case (i_state_q)
                I_IDLE: begin
                    if (Inst_Req_Valid) begin
                        i_state_q <= I_REQ;
                        i_cnt_q   <= REQ_CNT;
                    end
                end
                I_REQ: begin
                    if (!Inst_Req_Valid) begin
                        i_state_q <= I_IDLE;
                    end else if (inst_fire) begin
                        i_idx_q <= pc_idx;
                        if (DIRECT_RESP) begin
                            i_state_q    <= I_RESP;
                            instr_q      <= mem[pc_idx];
                            inst_valid_q <= 1'b1;
                        end else begin
                            i_state_q <= I_LAT;
                            i_cnt_q   <= LAT_CNT;
                        end
                    end else begin
                        i_cnt_q <= i_cnt_q - 4'd1;
                    end
                end
                I_LAT: begin
                    if (i_cnt_q == 4'd0) begin
                        i_state_q    <= I_RESP;
                        instr_q      <= mem[i_idx_q];
                        inst_valid_q <= 1'b1;
                    end else begin
                        i_cnt_q <= i_cnt_q - 4'd1;
                    end
                end
                I_RESP: begin
                    if (Inst_Ready) begin
                        inst_valid_q <= 1'b0;
                        i_state_q    <= I_IDLE;
                    end
                end
                default: i_state_q <= I_IDLE;
            endcase
        end
    end

    // Data channel FSM: stores finish at accept, loads follow the fetch timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state_q     <= D_IDLE;
            d_cnt_q       <= 4'd0;
            d_idx_q       <= '0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
        end else begin
            case (d_state_q)
                D_IDLE: begin
                    if (data_req) begin
                        d_state_q <= D_REQ;
                        d_cnt_q   <= REQ_CNT;
                    end
                end
                D_REQ: begin
                    if (!data_req) begin
                        d_state_q <= D_IDLE;
                    end else if (data_fire) begin
                        // A store (even one with MemRead also high) gets no response.
                        if (MemWrite) begin
                            d_state_q <= D_IDLE;
                        end else begin
                            d_idx_q <= addr_idx;
                            if (DIRECT_RESP) begin
                                d_state_q     <= D_RESP;
                                rdata_q       <= mem[addr_idx];
                                rdata_valid_q <= 1'b1;
                            end else begin
                                d_state_q <= D_LAT;
                                d_cnt_q   <= LAT_CNT;
                            end
                        end
                    end else begin
                        d_cnt_q <= d_cnt_q - 4'd1;
                    end
                end
                D_LAT: begin
                    if (d_cnt_q == 4'd0) begin
                        d_state_q     <= D_RESP;
                        rdata_q       <= mem[d_idx_q];
                        rdata_valid_q <= 1'b1;
                    end else begin
                        d_cnt_q <= d_cnt_q - 4'd1;
                    end
                end
                D_RESP: begin
                    if (Read_data_Ready) begin
                        rdata_valid_q <= 1'b0;
                        d_state_q     <= D_IDLE;
                    end
                end
                default: d_state_q <= D_IDLE;
            endcase
        end
    end

    // Sticky violation flag: abandoned requests and read+write collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (i_drop || d_drop || d_both) begin
            err_q <= 1'b1;
        end
    end

endmodule
